// File: rtl/sequence_generator_pkg.sv
// Shared constants for the serial pattern transmitter and the detector benches
// that consume its output.
package sequence_generator_pkg;

    // Default geometry: pattern length and repeat-count width.
    localparam int unsigned SG_WIDTH = 8;
    localparam int unsigned SG_CNT_W = 4;

    // Two-bit state encodings; the fourth code is unused and recovers to idle.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sequence_generator_if.sv
// Load handshake, bit-advance enable and serial output of the pattern transmitter.
interface sequence_generator_if
    import sequence_generator_pkg::*;
#(
    parameter int unsigned WIDTH = SG_WIDTH,
    parameter int unsigned CNT_W = SG_CNT_W
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] rep;
    logic             en;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    // Pattern source / consumer side.
    modport master (
        output load_valid, pattern, rep, en,
        input  load_ready, out, out_valid, busy, done
    );

    // Transmitter side.
    modport slave (
        input  load_valid, pattern, rep, en,
        output load_ready, out, out_valid, busy, done
    );

endinterface

// File: rtl/sequence_generator_bit_counter.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module bit_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Clear has priority over load, load over decrement; never wraps below zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: loads a WIDTH-bit pattern plus repeat count and
// shifts it out MSB-first, one bit per enabled clock, (rep+1) times.
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int unsigned WIDTH = SG_WIDTH,
    parameter int unsigned CNT_W = SG_CNT_W
) (
    input logic                 clk,
    input logic                 reset,
    sequence_generator_if.slave io
);

    localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] sh_q;
    logic [IDX_W-1:0] idx_q;
    logic             idx_zero;
    logic [CNT_W-1:0] rcnt_q;
    logic             rcnt_zero;
    logic             accept;
    logic             step;
    logic             wrap;
    logic             clear;

    // Per-cycle control strobes derived from the registered state.
    always_comb begin
        accept = (state_q == ST_IDLE) && io.load_valid;
        step   = (state_q == ST_SHIFT) && io.en;
        wrap   = step && idx_zero && (rcnt_q != '0);
        clear  = (state_q != ST_IDLE) && (state_q != ST_SHIFT) && (state_q != ST_DONE);
    end

    // Next-state selection; the unused code falls back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (step && idx_zero && rcnt_zero) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register and pattern capture on the load handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sh_q <= io.pattern;
            end else if (clear) begin
                sh_q <= '0;
            end
        end
    end

    bit_counter #(.W(IDX_W)) u_idx (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      (clear),
        .load_i     (accept || wrap),
        .load_val_i (IDX_LAST),
        .dec_i      (step && !idx_zero),
        .cnt_o      (idx_q),
        .zero_o     (idx_zero)
    );

    bit_counter #(.W(CNT_W)) u_rcnt (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      (clear),
        .load_i     (accept),
        .load_val_i (io.rep),
        .dec_i      (wrap),
        .cnt_o      (rcnt_q),
        .zero_o     (rcnt_zero)
    );

    // Moore output decode from registered state only.
    always_comb begin
        io.load_ready = 1'b0;
        io.out        = 1'b0;
        io.out_valid  = 1'b0;
        io.busy       = 1'b0;
        io.done       = 1'b0;
        case (state_q)
            ST_IDLE: io.load_ready = 1'b1;
            ST_SHIFT: begin
                io.out_valid = 1'b1;
                io.busy      = 1'b1;
                io.out       = sh_q[idx_q];
            end
            ST_DONE: begin
                io.busy = 1'b1;
                io.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
